envelope: RTL and testbench
===========================

ENVELOPE -- requirements
Module: envelope

Interface
REQ-001 clk  input  1  Envelope clock (quarter-frame tick); all state SHALL update on its rising edge.
REQ-002 rst_n  input  1  Reset; one clock domain, asynchronous assert, active-low.
REQ-003 loop  input  1  When 1, the decay counter SHALL reload to 15 after reaching 0; when 0, it SHALL hold at 0.
REQ-004 disableFlag  input  1  When 1, the output SHALL be constant volume (n); when 0, it SHALL be the decay level.
REQ-005 resetFlag  input  1  Envelope start request, level-sampled on each clk rising edge.
REQ-006 n  input  4  Divider period (reload value) and constant-volume level.
REQ-007 volume  output  4  Current envelope volume.

Function
REQ-008 State SHALL be a 4-bit divider counter and a 4-bit decay counter.
REQ-009 At a rising edge with resetFlag=1, decay SHALL be set to 15 and divider to n; there SHALL be no other state change that edge, regardless of loop.
REQ-010 At a rising edge with resetFlag=0 and divider≠0, divider SHALL decrement by 1 and decay SHALL hold.
REQ-011 At a rising edge with resetFlag=0 and divider=0, divider SHALL reload to n and decay SHALL be clocked as follows.
REQ-012 Decay clocking: decay>0 -> decay−1; decay=0 and loop=1 -> 15; decay=0 and loop=0 -> hold 0.
REQ-013 Decay therefore SHALL step once every n+1 edges after a start, including n=0 (a step every edge).
REQ-014 volume SHALL be combinational: disableFlag ? n : decay, with no added latency; changes to disableFlag or n SHALL appear without waiting for a clock.
REQ-015 Counters SHALL be unsigned 4-bit, with no wrap below 0 other than the loop reload to 15.
REQ-016 The envelope SHALL keep running (divider and decay) while disableFlag=1, so that deasserting it shows the current decay.
REQ-017 A change of n mid-count SHALL take effect at the next reload or start only.
REQ-018 Holding resetFlag high SHALL keep reloading every edge: decay stays 15 and divider stays n.

Reset
REQ-019 When rst_n=0, decay and divider SHALL clear to 0 immediately, independent of clk.
REQ-020 During reset, volume SHALL equal disableFlag ? n : 0.
REQ-021 After rst_n rises, operation SHALL resume at the next clk edge with the REQ-009..012 rules.
REQ-022 Reset mid-decay SHALL discard all progress.

Structure
REQ-023 A shared package SHALL hold the constants VOL_W=4 and DECAY_MAX=4'd15.
REQ-024 The divider SHALL be a sub-module envelope_divider.
- Ports: clk, rst_n, load, period[3:0], tick output.
- Behaviour: reloadable down-counter that pulses tick when its count is 0.
REQ-025 The decay counter and output mux SHALL reside in envelope.

Verification
REQ-026 Reset: rst_n=0, disableFlag=0 -> volume=0; then disableFlag=1, n=7 -> volume=7 with no clock.
REQ-027 Start and decay, n=3, loop=0, disableFlag=0:
- resetFlag=1 for one edge -> volume=15.
- volume SHALL step 14, 13, ... 0 every 4 edges.
- volume SHALL remain 0 indefinitely.
REQ-028 Loop, n=3, loop=1: after reaching 0, the 4th following edge -> volume=15, then decay repeats.
REQ-029 Constant volume: disableFlag=1, n=3 -> volume=3 at all times; deassert -> the ongoing decay value appears immediately.
REQ-030 Period 0: n=0, start -> volume decrements every edge, 15 down to 0 in 15 edges.
REQ-031 Re-start mid-decay: resetFlag=1 while volume=9 -> volume=15 at that edge, and the divider restarts from n.

Source files
------------

// File: rtl/envelope_pkg.sv
// Shared widths and constants for the envelope generator.
package envelope_pkg;
    localparam int              VOL_W     = 4;
    localparam logic [VOL_W-1:0] DECAY_MAX = 4'd15;
endpackage

// File: rtl/envelope_if.sv
// Control/volume bundle between the sequencer (master) and the envelope (slave).
interface envelope_if;
    import envelope_pkg::*;
    logic             loop;
    logic             disableFlag;
    logic             resetFlag;
    logic [VOL_W-1:0] n;
    logic [VOL_W-1:0] volume;

    modport master (output loop, output disableFlag, output resetFlag, output n, input volume);
    modport slave  (input loop, input disableFlag, input resetFlag, input n, output volume);
endinterface

// File: rtl/envelope_divider.sv
// Reloadable down-counter; tick is high while the count sits at zero.
module envelope_divider
    import envelope_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [VOL_W-1:0] period,
    output logic             tick
);
    logic [VOL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load || (cnt_q == '0)) begin
            cnt_d = period;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/envelope.sv
// Envelope generator: divider-paced decay counter with optional loop and a
// constant-volume bypass on the output.
module envelope
    import envelope_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    envelope_if.slave bus
);
    logic             div_tick;
    logic [VOL_W-1:0] decay_q, decay_d;

    envelope_divider u_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (bus.resetFlag),
        .period (bus.n),
        .tick   (div_tick)
    );

    // A start request overrides the divider tick on the same edge.
    always_comb begin
        decay_d = decay_q;
        if (bus.resetFlag) begin
            decay_d = DECAY_MAX;
        end else if (div_tick) begin
            if (decay_q != '0) begin
                decay_d = decay_q - 1'b1;
            end else if (bus.loop) begin
                decay_d = DECAY_MAX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decay_q <= '0;
        end else begin
            decay_q <= decay_d;
        end
    end

    assign bus.volume = bus.disableFlag ? bus.n : decay_q;
endmodule

// File: tb/tb_envelope.sv
// Self-checking bench for envelope: directed scenarios plus randomized traffic
// against a rule-level model checked every cycle.
module tb_envelope;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   model_chk = 1'b0;

    envelope_if bus ();

    envelope dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int m_div = 0;
    int m_dec = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div = 0;
            m_dec = 0;
        end else if (bus.resetFlag) begin
            m_dec = 15;
            m_div = int'(bus.n);
        end else if (m_div != 0) begin
            m_div = m_div - 1;
        end else begin
            m_div = int'(bus.n);
            if (m_dec > 0) m_dec = m_dec - 1;
            else if (bus.loop) m_dec = 15;
        end
    end

    always @(negedge clk) begin
        if (model_chk) begin
            int exp_v;
            exp_v = bus.disableFlag ? int'(bus.n) : (rst_n ? m_dec : 0);
            total++;
            if (int'(bus.volume) != exp_v) begin
                bad++;
                $display("FAIL model_vol t=%0t got=%0d want=%0d", $time, bus.volume, exp_v);
            end
        end
    end

    task automatic check(input string name, input int want);
        total++;
        if (int'(bus.volume) != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, bus.volume, want);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin
        bus.loop = 1'b0;
        bus.disableFlag = 1'b0;
        bus.resetFlag = 1'b0;
        bus.n = 4'd0;
        #3;
        check("rst_vol0", 0);
        bus.disableFlag = 1'b1;
        bus.n = 4'd7;
        #1;
        check("rst_const7", 7);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_chk = 1'b1;

        // start and one-shot decay, n=3
        bus.disableFlag = 1'b0;
        bus.n = 4'd3;
        bus.resetFlag = 1'b1;
        step(1);
        check("start15", 15);
        bus.resetFlag = 1'b0;
        for (int i = 14; i >= 0; i--) begin
            step(4);
            check("decay_n3", i);
        end
        step(20);
        check("hold0", 0);

        // looping decay
        bus.loop = 1'b1;
        bus.resetFlag = 1'b1;
        step(1);
        bus.resetFlag = 1'b0;
        step(60);
        check("loop_at0", 0);
        step(3);
        check("loop_wait", 0);
        step(1);
        check("loop_reload15", 15);
        step(4);
        check("loop_repeat14", 14);

        // constant volume while decay keeps running underneath
        bus.disableFlag = 1'b1;
        #1;
        check("const3_now", 3);
        step(3);
        check("const3_later", 3);
        bus.disableFlag = 1'b0;
        #1;
        check("undisable_14", 14);

        // period 0
        bus.loop = 1'b0;
        bus.n = 4'd0;
        bus.resetFlag = 1'b1;
        step(1);
        check("p0_start", 15);
        bus.resetFlag = 1'b0;
        for (int i = 14; i >= 0; i--) begin
            step(1);
            check("p0_decay", i);
        end

        // restart mid-decay at volume 9
        bus.n = 4'd3;
        bus.resetFlag = 1'b1;
        step(1);
        bus.resetFlag = 1'b0;
        step(24);
        check("mid_9", 9);
        bus.resetFlag = 1'b1;
        step(1);
        check("restart15", 15);
        bus.resetFlag = 1'b0;
        step(3);
        check("restart_div_hold", 15);
        step(1);
        check("restart_div_14", 14);

        // held resetFlag keeps reloading
        bus.resetFlag = 1'b1;
        step(10);
        check("held_start", 15);
        bus.resetFlag = 1'b0;

        // n change mid-count only applies at next reload
        step(1);
        bus.n = 4'd1;
        step(3);
        check("nchg_old_period", 14);
        step(2);
        check("nchg_new_period", 13);

        // async reset mid-decay
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("post_rst_idle", 0);

        // randomized traffic, model-checked every cycle
        for (int c = 0; c < 3000; c++) begin
            step(1);
            bus.resetFlag = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) bus.n = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus.loop = ~bus.loop;
            if ($urandom_range(0, 15) == 0) bus.disableFlag = ~bus.disableFlag;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_async_rst", bus.disableFlag ? int'(bus.n) : 0);
                rst_n = 1'b1;
            end
        end

        step(1);
        model_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
